// File: rtl/ball_pkg.sv
// Shared types and constants for the ball sprite scanner: size codes, update FSM
// states and the bounding-box width helper.
package ball_pkg;

    localparam int unsigned COORD_W    = 11;
    localparam int unsigned BITMAP_DIM = 32;

    typedef enum logic [1:0] {
        SIZE_64 = 2'd0,
        SIZE_32 = 2'd1,
        SIZE_16 = 2'd2,
        SIZE_8  = 2'd3
    } size_code_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } upd_state_t;

    // On-screen edge length of the ball box for a given size code.
    function automatic logic [6:0] box_width(input size_code_t s);
        return 7'd64 >> s;
    endfunction

endpackage

// File: rtl/rect_offset_scale.sv
// Combinational box test for one ball plus scaling of the in-box offset into
// 32x32 bitmap coordinates.
module rect_offset_scale
    import ball_pkg::*;
(
    input  logic [COORD_W-1:0] pos_x_i,
    input  logic [COORD_W-1:0] pos_y_i,
    input  size_code_t         size_i,
    input  logic               enable_i,
    input  logic [COORD_W-1:0] pixel_x_i,
    input  logic [COORD_W-1:0] pixel_y_i,
    output logic               inside_o,
    output logic [4:0]         off_x_o,
    output logic [4:0]         off_y_o
);

    logic [COORD_W:0] dx;
    logic [COORD_W:0] dy;
    logic [6:0]       width;
    logic             in_x;
    logic             in_y;

    // Unsigned pixel minus sign-extended top-left; a negative result never hits.
    assign dx    = {1'b0, pixel_x_i} - {pos_x_i[COORD_W-1], pos_x_i};
    assign dy    = {1'b0, pixel_y_i} - {pos_y_i[COORD_W-1], pos_y_i};
    assign width = box_width(size_i);

    assign in_x     = !dx[COORD_W] && (dx < {5'b0, width});
    assign in_y     = !dy[COORD_W] && (dy < {5'b0, width});
    assign inside_o = enable_i && in_x && in_y;

    always_comb begin
        off_x_o = '0;
        off_y_o = '0;
        case (size_i)
            SIZE_64: begin
                off_x_o = dx[5:1];
                off_y_o = dy[5:1];
            end
            SIZE_32: begin
                off_x_o = dx[4:0];
                off_y_o = dy[4:0];
            end
            SIZE_16: begin
                off_x_o = {dx[3:0], 1'b0};
                off_y_o = {dy[3:0], 1'b0};
            end
            SIZE_8: begin
                off_x_o = {dx[2:0], 2'b0};
                off_y_o = {dy[2:0], 2'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ball_rect_scanner.sv
// Ball sprite read-interface driver: frame-latched position/size with a
// pending/ack update handshake, and registered bitmap offsets.
module ball_rect_scanner
    import ball_pkg::*;
#(
    parameter int INIT_X    = 304,
    parameter int INIT_Y    = 100,
    parameter int INIT_SIZE = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        posUpdate,
    input  logic [10:0] newTopLeftX,
    input  logic [10:0] newTopLeftY,
    input  logic [1:0]  newSize,
    input  logic        newEnable,
    output logic        posAck,
    output logic        updatePending,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle
);

    localparam logic [COORD_W-1:0] RST_X    = COORD_W'(INIT_X);
    localparam logic [COORD_W-1:0] RST_Y    = COORD_W'(INIT_Y);
    localparam size_code_t         RST_SIZE = size_code_t'(2'(INIT_SIZE));

    upd_state_t         state_q, state_d;
    logic [COORD_W-1:0] shd_x_q, shd_y_q;
    size_code_t         shd_size_q;
    logic               shd_en_q;
    logic [COORD_W-1:0] act_x_q, act_x_d, act_y_q, act_y_d;
    size_code_t         act_size_q, act_size_d;
    logic               act_en_q, act_en_d;
    logic               ack_q, ack_d;
    logic               inside_q;
    logic [4:0]         off_x_q, off_y_q;

    logic               inside_c;
    logic [4:0]         off_x_c, off_y_c;

    always_comb begin
        state_d    = state_q;
        act_x_d    = act_x_q;
        act_y_d    = act_y_q;
        act_size_d = act_size_q;
        act_en_d   = act_en_q;
        ack_d      = 1'b0;
        if (startOfFrame && posUpdate) begin
            // Same-cycle update skips the shadow and lands at this frame start.
            act_x_d    = newTopLeftX;
            act_y_d    = newTopLeftY;
            act_size_d = size_code_t'(newSize);
            act_en_d   = newEnable;
            ack_d      = 1'b1;
            state_d    = IDLE;
        end else if (startOfFrame && state_q == PENDING) begin
            act_x_d    = shd_x_q;
            act_y_d    = shd_y_q;
            act_size_d = shd_size_q;
            act_en_d   = shd_en_q;
            ack_d      = 1'b1;
            state_d    = IDLE;
        end else if (posUpdate) begin
            state_d = PENDING;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            shd_x_q    <= RST_X;
            shd_y_q    <= RST_Y;
            shd_size_q <= RST_SIZE;
            shd_en_q   <= 1'b1;
            act_x_q    <= RST_X;
            act_y_q    <= RST_Y;
            act_size_q <= RST_SIZE;
            act_en_q   <= 1'b1;
            ack_q      <= 1'b0;
            inside_q   <= 1'b0;
            off_x_q    <= '0;
            off_y_q    <= '0;
        end else begin
            state_q <= state_d;
            if (posUpdate) begin
                shd_x_q    <= newTopLeftX;
                shd_y_q    <= newTopLeftY;
                shd_size_q <= size_code_t'(newSize);
                shd_en_q   <= newEnable;
            end
            act_x_q    <= act_x_d;
            act_y_q    <= act_y_d;
            act_size_q <= act_size_d;
            act_en_q   <= act_en_d;
            ack_q      <= ack_d;
            inside_q   <= inside_c;
            off_x_q    <= inside_c ? off_x_c : '0;
            off_y_q    <= inside_c ? off_y_c : '0;
        end
    end

    rect_offset_scale u_scale (
        .pos_x_i   (act_x_q),
        .pos_y_i   (act_y_q),
        .size_i    (act_size_q),
        .enable_i  (act_en_q),
        .pixel_x_i (pixelX),
        .pixel_y_i (pixelY),
        .inside_o  (inside_c),
        .off_x_o   (off_x_c),
        .off_y_o   (off_y_c)
    );

    assign posAck          = ack_q;
    assign updatePending   = (state_q == PENDING);
    assign InsideRectangle = inside_q;
    assign offsetX         = {6'b0, off_x_q};
    assign offsetY         = {6'b0, off_y_q};

endmodule

// File: tb/tb_ball_rect_scanner.sv
// Directed self-checking bench for ball_rect_scanner with hand-computed expectations.
module tb_ball_rect_scanner;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, posUpdate;
    logic [10:0] newTopLeftX, newTopLeftY;
    logic [1:0]  newSize;
    logic        newEnable;
    logic        posAck, updatePending, InsideRectangle;
    logic [10:0] offsetX, offsetY;

    int checks   = 0;
    int failures = 0;

    ball_rect_scanner #(.INIT_X(304), .INIT_Y(100), .INIT_SIZE(1)) dut (
        .clk             (clk),
        .resetN          (resetN),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .startOfFrame    (startOfFrame),
        .posUpdate       (posUpdate),
        .newTopLeftX     (newTopLeftX),
        .newTopLeftY     (newTopLeftY),
        .newSize         (newSize),
        .newEnable       (newEnable),
        .posAck          (posAck),
        .updatePending   (updatePending),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .InsideRectangle (InsideRectangle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pix(input string tag, input int x, input int y,
                           input logic ins, input int ox, input int oy);
        pixelX = 11'(x);
        pixelY = 11'(y);
        tick();
        chk({tag, "_in"}, {31'b0, InsideRectangle}, {31'b0, ins});
        chk({tag, "_ox"}, {21'b0, offsetX}, 32'(ox));
        chk({tag, "_oy"}, {21'b0, offsetY}, 32'(oy));
    endtask

    task automatic upd(input int x, input int y, input int sz, input logic en);
        posUpdate   = 1'b1;
        newTopLeftX = 11'(x);
        newTopLeftY = 11'(y);
        newSize     = 2'(sz);
        newEnable   = en;
    endtask

    initial begin
        resetN = 1'b0; pixelX = '0; pixelY = '0;
        startOfFrame = 1'b0; posUpdate = 1'b0;
        newTopLeftX = '0; newTopLeftY = '0; newSize = '0; newEnable = 1'b0;
        #12;
        chk("rst_in", {31'b0, InsideRectangle}, 32'd0);
        chk("rst_ox", {21'b0, offsetX}, 32'd0);
        chk("rst_oy", {21'b0, offsetY}, 32'd0);
        chk("rst_ack", {31'b0, posAck}, 32'd0);
        chk("rst_pend", {31'b0, updatePending}, 32'd0);
        resetN = 1'b1;
        tick();

        // Reset position (304,100), 32px box.
        chk_pix("init_tl", 304, 100, 1'b1, 0, 0);
        chk_pix("init_br", 335, 131, 1'b1, 31, 31);
        chk_pix("init_right", 336, 100, 1'b0, 0, 0);
        chk_pix("init_left", 303, 100, 1'b0, 0, 0);

        // Idle frame start without an update leaves everything unchanged.
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        chk("idle_sof_ack", {31'b0, posAck}, 32'd0);
        chk_pix("idle_sof_tl", 304, 100, 1'b1, 0, 0);

        // Mid-frame update is held until frame start.
        upd(10, 20, 0, 1'b1); tick(); posUpdate = 1'b0;
        chk("t2_pend", {31'b0, updatePending}, 32'd1);
        chk("t2_ack0", {31'b0, posAck}, 32'd0);
        chk_pix("t2_old", 320, 116, 1'b1, 16, 16);
        chk("t2_pend2", {31'b0, updatePending}, 32'd1);
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        chk("t2_ack", {31'b0, posAck}, 32'd1);
        chk("t2_pend_clr", {31'b0, updatePending}, 32'd0);
        tick();
        chk("t2_ack_1cyc", {31'b0, posAck}, 32'd0);
        chk_pix("t2_br", 73, 83, 1'b1, 31, 31);
        chk_pix("t2_mid", 30, 40, 1'b1, 10, 10);
        chk_pix("t2_out", 74, 20, 1'b0, 0, 0);

        // Two updates before the frame: last one wins, one ack.
        upd(50, 20, 3, 1'b1); tick();
        upd(60, 20, 3, 1'b1); tick(); posUpdate = 1'b0;
        chk("t3_pend", {31'b0, updatePending}, 32'd1);
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        chk("t3_ack", {31'b0, posAck}, 32'd1);
        tick();
        chk("t3_ack_1cyc", {31'b0, posAck}, 32'd0);
        chk_pix("t3_in", 67, 20, 1'b1, 28, 0);
        chk_pix("t3_y", 61, 27, 1'b1, 4, 28);
        chk_pix("t3_out", 68, 20, 1'b0, 0, 0);
        chk_pix("t3_old_x", 50, 20, 1'b0, 0, 0);

        // Coincident update and frame start: immediate commit, no pending.
        upd(-4, 0, 1, 1'b1); startOfFrame = 1'b1;
        tick(); posUpdate = 1'b0; startOfFrame = 1'b0;
        chk("t4_ack", {31'b0, posAck}, 32'd1);
        chk("t4_pend", {31'b0, updatePending}, 32'd0);
        chk_pix("t4_x0", 0, 0, 1'b1, 4, 0);
        chk("t4_ack_1cyc", {31'b0, posAck}, 32'd0);
        chk_pix("t4_x27", 27, 0, 1'b1, 31, 0);
        chk_pix("t4_x28", 28, 0, 1'b0, 0, 0);

        // Disabled ball: never inside.
        upd(0, 0, 0, 1'b0); startOfFrame = 1'b1;
        tick(); posUpdate = 1'b0; startOfFrame = 1'b0;
        chk("t5_ack", {31'b0, posAck}, 32'd1);
        chk_pix("t5_a", 0, 0, 1'b0, 0, 0);
        chk_pix("t5_b", 10, 10, 1'b0, 0, 0);
        chk_pix("t5_c", 63, 63, 1'b0, 0, 0);

        // Reset while pending discards the shadow and the ack.
        upd(100, 200, 2, 1'b1); tick(); posUpdate = 1'b0;
        chk("t6_pend", {31'b0, updatePending}, 32'd1);
        #2 resetN = 1'b0;
        #1;
        chk("t6_rst_pend", {31'b0, updatePending}, 32'd0);
        chk("t6_rst_ack", {31'b0, posAck}, 32'd0);
        #1 resetN = 1'b1;
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        chk("t6_no_ack", {31'b0, posAck}, 32'd0);
        chk_pix("t6_init_tl", 304, 100, 1'b1, 0, 0);
        chk_pix("t6_init_br", 335, 131, 1'b1, 31, 31);
        chk_pix("t6_shadow", 100, 200, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ball_rect_scanner.md
Name: ball_rect_scanner

Overview:
- Drives the sprite-bitmap read interface (offsetX, offsetY, InsideRectangle) for one ball.
- Compares the VGA scan position with the ball's frame-latched bounding box and scales the in-box offset into 32x32 bitmap coordinates, so one bitmap serves all four ball sizes.
- Accepts position/size updates from ball physics through a pending/ack handshake; updates take effect only at frame start, so there is no tearing.
- Sits between the VGA sync/physics logic and the ball bitmap ROM reader.

Parameters:
- INIT_X, 304, reset top-left X (signed 11-bit).
- INIT_Y, 100, reset top-left Y (signed 11-bit).
- INIT_SIZE, 1, reset size code (0=64px, 1=32px, 2=16px, 3=8px).

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- pixelX  in  11  current scan X, unsigned 0..639
- pixelY  in  11  current scan Y, unsigned 0..479
- startOfFrame  in  1  one-cycle pulse before the first pixel of a frame
- posUpdate  in  1  physics strobe: new position/size valid
- newTopLeftX  in  11  signed two's-complement top-left X
- newTopLeftY  in  11  signed two's-complement top-left Y
- newSize  in  2  size code
- newEnable  in  1  ball visible when 1
- posAck  out  1  one-cycle pulse: pending update committed
- updatePending  out  1  an update is waiting for frame start
- offsetX  out  11  bitmap column 0..31, zero-extended
- offsetY  out  11  bitmap row 0..31, zero-extended
- InsideRectangle  out  1  scan pixel lies inside the active ball box

Behaviour:
- Reset values (async, resetN low):
  - Outputs: offsetX=0, offsetY=0, InsideRectangle=0, posAck=0, updatePending=0.
  - Active registers: X=INIT_X, Y=INIT_Y, size=INIT_SIZE, enable=1.
  - FSM: IDLE.
- Update FSM, states IDLE and PENDING:
  - posUpdate in any state captures newTopLeftX/Y, newSize and newEnable into shadow registers. The last write wins, with no error.
  - IDLE, posUpdate, no startOfFrame -> PENDING.
  - PENDING, startOfFrame -> shadow copied to active; posAck=1 for exactly one cycle; -> IDLE.
  - posUpdate and startOfFrame in the same cycle, either state -> the new input values bypass the shadow and become active at that frame start; posAck pulses; -> IDLE.
  - startOfFrame in IDLE with no update -> active registers unchanged, no ack.
  - updatePending = (state == PENDING).
  - Reset mid-PENDING discards the shadow; the ack is never issued.
- Box test:
  - W = 64 >> size, giving 64/32/16/8.
  - dx = {1'b0,pixelX} - sext(activeX) and dy likewise, in 12-bit signed.
  - inside = enable && 0 <= dx < W && 0 <= dy < W.
  - Negative or off-screen top-left values clip naturally; no wrap-around hits are allowed.
- Scaling into the 32-px bitmap:
  - size 0: off = dx >> 1
  - size 1: off = dx
  - size 2: off = dx << 1
  - size 3: off = dx << 2
  - The result is always 0..31; keep the low 5 bits and zero-extend to 11.
- Output timing:
  - Outputs are registered with a latency of 1 clk from pixelX/pixelY.
  - When not inside, offsetX = offsetY = 0 and InsideRectangle = 0.
  - The downstream bitmap reader adds 1 more cycle; the VGA path delays its own coordinates by 2 to match.
- Active registers change only on startOfFrame (or reset), never mid-frame.

Decomposition:
- Shared package ball_pkg:
  - size_code_t enum: SIZE_64, SIZE_32, SIZE_16, SIZE_8
  - BITMAP_DIM = 32
  - COORD_W = 11
  - upd_state_t enum: IDLE, PENDING
- One sub-module, rect_offset_scale, is the natural split: a combinational box test plus scaling (active pos, size, pixel -> inside, offsets). The top level holds the FSM, the shadow/active registers and the output registers.

Test Plan:
- Reset, no updates; pixel (304,100) -> 1 clk later InsideRectangle=1, offsets (0,0). Pixel (335,131) -> (31,31). Pixel (336,100) -> InsideRectangle=0, offsets 0.
- posUpdate X=10, Y=20, size=0 mid-frame -> updatePending=1, no effect on outputs. After startOfFrame -> posAck single pulse. Pixel (73,83) -> offsets (31,31). Pixel (74,20) -> outside.
- Two posUpdates (X=50 then X=60) before the frame, size=3 -> X=60 is active. Pixel (67,Y) -> offsetX=28. Pixel (68,Y) -> outside. Exactly one posAck.
- posUpdate coincident with startOfFrame, X=-4, Y=0, size=1 -> immediate commit and ack, updatePending stays 0. Pixel (0,0) -> offsetX=4. Pixel (27,0) -> offsetX=31.
- newEnable=0 committed -> InsideRectangle=0 across the whole frame. resetN low while PENDING -> updatePending=0, INIT position restored, no posAck.
